// File: rtl/dial_tracker.sv
// Handshaked modulo-MODULUS dial that counts landings on 0 and every click showing 0.
// Optional DIAL_CNT_SAT_EN: counters saturate and raise a sticky ovf instead of wrapping.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command; in_ready follows en
// REDUCE | strip full revolutions from rem, then apply the remainder
module dial_tracker #(
    parameter int MODULUS = 100,
    parameter int START   = 50,
    parameter int MAG_W   = 10,
    parameter int CNT_W   = 16,
    parameter int POS_W   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             dir,
    input  logic [MAG_W-1:0] mag,
    output logic [POS_W-1:0] pos,
    output logic [CNT_W-1:0] land_cnt,
    output logic [CNT_W-1:0] cross_cnt,
    output logic             done,
    output logic             busy,
    output logic             ovf
);

    localparam int AW = (MAG_W > POS_W + 1) ? MAG_W : POS_W + 1;
    localparam logic [AW-1:0] MOD_A = AW'(MODULUS);

    typedef enum logic [0:0] {IDLE, REDUCE} state_t;

    state_t           state, state_nxt;
    logic             dir_q, dir_nxt;
    logic [MAG_W-1:0] rem, rem_nxt;
    logic [POS_W-1:0] pos_q, pos_nxt;
    logic [CNT_W-1:0] land_q, land_nxt;
    logic [CNT_W-1:0] cross_q, cross_nxt;
    logic             ovf_q, ovf_nxt;
    logic             done_r;
    logic             final_edge, cross_inc, land_inc;
    logic [AW-1:0]    rem_a, pos_a, sum_a;

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir_q;
        rem_nxt    = rem;
        pos_nxt    = pos_q;
        final_edge = 1'b0;
        cross_inc  = 1'b0;
        land_inc   = 1'b0;
        rem_a      = AW'(rem);
        pos_a      = AW'(pos_q);
        sum_a      = pos_a + rem_a;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    dir_nxt   = dir;
                    rem_nxt   = mag;
                    state_nxt = REDUCE;
                end
            end
            REDUCE: begin
                if (rem_a >= MOD_A) begin
                    // a full revolution passes 0 exactly once
                    rem_nxt   = MAG_W'(rem_a - MOD_A);
                    cross_inc = 1'b1;
                end else begin
                    final_edge = 1'b1;
                    state_nxt  = IDLE;
                    if (!dir_q) begin
                        if (sum_a >= MOD_A) begin
                            pos_nxt   = POS_W'(sum_a - MOD_A);
                            cross_inc = 1'b1;
                        end else begin
                            pos_nxt = POS_W'(sum_a);
                        end
                    end else if (rem_a == '0) begin
                        pos_nxt = pos_q;
                    end else if (pos_a == '0) begin
                        // leaving 0 to the left does not show 0 again
                        pos_nxt = POS_W'(MOD_A - rem_a);
                    end else if (rem_a == pos_a) begin
                        pos_nxt   = '0;
                        cross_inc = 1'b1;
                    end else if (rem_a > pos_a) begin
                        pos_nxt   = POS_W'(pos_a + MOD_A - rem_a);
                        cross_inc = 1'b1;
                    end else begin
                        pos_nxt = POS_W'(pos_a - rem_a);
                    end
                    land_inc = (pos_nxt == '0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        land_nxt  = land_q;
        cross_nxt = cross_q;
        ovf_nxt   = ovf_q;
`ifdef DIAL_CNT_SAT_EN
        if (land_inc) begin
            if (&land_q) ovf_nxt = 1'b1;
            else         land_nxt = land_q + CNT_W'(1);
        end
        if (cross_inc) begin
            if (&cross_q) ovf_nxt = 1'b1;
            else          cross_nxt = cross_q + CNT_W'(1);
        end
`else
        if (land_inc)  land_nxt  = land_q + CNT_W'(1);
        if (cross_inc) cross_nxt = cross_q + CNT_W'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            dir_q   <= 1'b0;
            rem     <= '0;
            pos_q   <= POS_W'(START);
            land_q  <= '0;
            cross_q <= '0;
            ovf_q   <= 1'b0;
            done_r  <= 1'b0;
        end else if (en) begin
            state   <= state_nxt;
            dir_q   <= dir_nxt;
            rem     <= rem_nxt;
            pos_q   <= pos_nxt;
            land_q  <= land_nxt;
            cross_q <= cross_nxt;
            ovf_q   <= ovf_nxt;
            done_r  <= final_edge;
        end
    end

    // a pulse caught by en=0 is held and shown once en returns
    assign done      = done_r & en;
    assign in_ready  = (state == IDLE) & en;
    assign busy      = (state != IDLE);
    assign pos       = pos_q;
    assign land_cnt  = land_q;
    assign cross_cnt = cross_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dial_tracker.sv
// Directed self-checking bench for dial_tracker (default instance plus a CNT_W=2 instance).
module tb_dial_tracker;

    logic        clk, rst, en;
    logic        in_valid, dir, in_ready, done, busy, ovf;
    logic [9:0]  mag;
    logic [6:0]  pos;
    logic [15:0] land_cnt, cross_cnt;

    logic        s_valid, s_dir, s_ready, s_done, s_busy, s_ovf;
    logic [9:0]  s_mag;
    logic [6:0]  s_pos;
    logic [1:0]  s_land, s_cross;

    int n_cmp = 0;
    int n_bad = 0;

    dial_tracker dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .dir(dir), .mag(mag), .pos(pos), .land_cnt(land_cnt), .cross_cnt(cross_cnt),
        .done(done), .busy(busy), .ovf(ovf)
    );

    dial_tracker #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .en(en), .in_valid(s_valid), .in_ready(s_ready),
        .dir(s_dir), .mag(s_mag), .pos(s_pos), .land_cnt(s_land), .cross_cnt(s_cross),
        .done(s_done), .busy(s_busy), .ovf(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // issue one command to the selected instance and count edges until done
    task automatic run_cmd(input logic sel, input logic d, input logic [9:0] m, output int lat);
        logic rdy;
        rdy = sel ? s_ready : in_ready;
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_before_cmd: got %b want 1", rdy);
        end
        if (sel) begin s_dir = d; s_mag = m; s_valid = 1'b1; end
        else     begin dir = d;   mag = m;   in_valid = 1'b1; end
        @(posedge clk); #1;
        s_valid = 1'b0;
        in_valid = 1'b0;
        lat = 0;
        while (((sel ? s_done : done) !== 1'b1) && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat >= 2000) begin
            n_bad++;
            $display("FAIL done_timeout: got no done after %0d edges want done", lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pos !== 7'd50)       begin n_bad++; $display("FAIL rst_pos: got %0d want 50", pos); end
        n_cmp++; if (land_cnt !== 16'd0)  begin n_bad++; $display("FAIL rst_land: got %0d want 0", land_cnt); end
        n_cmp++; if (cross_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cross: got %0d want 0", cross_cnt); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (ovf !== 1'b0)        begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        dir = 1'b0; mag = 10'd500; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cross_cnt !== 16'd2) begin n_bad++; $display("FAIL mid_cross: got %0d want 2", cross_cnt); end
        do_reset();
        n_cmp++; if (pos !== 7'd50)       begin n_bad++; $display("FAIL midrst_pos: got %0d want 50", pos); end
        n_cmp++; if (cross_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_cross: got %0d want 0", cross_cnt); end
        n_cmp++; if (land_cnt !== 16'd0)  begin n_bad++; $display("FAIL midrst_land: got %0d want 0", land_cnt); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    endtask

    task automatic test_sequence();
        logic       dirs [10] = '{1, 1, 0, 1, 0, 1, 1, 1, 0, 1};
        logic [9:0] mags [10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
        logic [6:0] exps [10] = '{82, 52, 0, 95, 55, 0, 99, 0, 14, 32};
        int lat;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_cmd(1'b0, dirs[i], mags[i], lat);
            n_cmp++;
            if (pos !== exps[i]) begin n_bad++; $display("FAIL seq_pos[%0d]: got %0d want %0d", i, pos, exps[i]); end
            n_cmp++;
            if (lat != 1) begin n_bad++; $display("FAIL seq_lat[%0d]: got %0d want 1", i, lat); end
        end
        n_cmp++; if (land_cnt !== 16'd3)  begin n_bad++; $display("FAIL seq_land: got %0d want 3", land_cnt); end
        n_cmp++; if (cross_cnt !== 16'd6) begin n_bad++; $display("FAIL seq_cross: got %0d want 6", cross_cnt); end
    endtask

    task automatic test_long();
        int lat;
        do_reset();
        run_cmd(1'b0, 1'b0, 10'd1000, lat);
        n_cmp++; if (lat != 11)            begin n_bad++; $display("FAIL long_lat: got %0d want 11", lat); end
        n_cmp++; if (pos !== 7'd50)        begin n_bad++; $display("FAIL long_pos: got %0d want 50", pos); end
        n_cmp++; if (cross_cnt !== 16'd10) begin n_bad++; $display("FAIL long_cross: got %0d want 10", cross_cnt); end
        n_cmp++; if (land_cnt !== 16'd0)   begin n_bad++; $display("FAIL long_land: got %0d want 0", land_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0)        begin n_bad++; $display("FAIL long_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_from_zero();
        int lat;
        do_reset();
        run_cmd(1'b0, 1'b0, 10'd50, lat);
        n_cmp++; if (pos !== 7'd0)        begin n_bad++; $display("FAIL z0_pos: got %0d want 0", pos); end
        run_cmd(1'b0, 1'b1, 10'd5, lat);
        n_cmp++; if (pos !== 7'd95)       begin n_bad++; $display("FAIL z1_pos: got %0d want 95", pos); end
        n_cmp++; if (cross_cnt !== 16'd1) begin n_bad++; $display("FAIL z1_cross: got %0d want 1", cross_cnt); end
        run_cmd(1'b0, 1'b0, 10'd5, lat);
        n_cmp++; if (pos !== 7'd0)        begin n_bad++; $display("FAIL z2_pos: got %0d want 0", pos); end
        n_cmp++; if (cross_cnt !== 16'd2) begin n_bad++; $display("FAIL z2_cross: got %0d want 2", cross_cnt); end
        n_cmp++; if (land_cnt !== 16'd2)  begin n_bad++; $display("FAIL z2_land: got %0d want 2", land_cnt); end
        run_cmd(1'b0, 1'b1, 10'd0, lat);
        n_cmp++; if (lat != 1)            begin n_bad++; $display("FAIL z3_lat: got %0d want 1", lat); end
        n_cmp++; if (pos !== 7'd0)        begin n_bad++; $display("FAIL z3_pos: got %0d want 0", pos); end
        n_cmp++; if (land_cnt !== 16'd3)  begin n_bad++; $display("FAIL z3_land: got %0d want 3", land_cnt); end
        n_cmp++; if (cross_cnt !== 16'd2) begin n_bad++; $display("FAIL z3_cross: got %0d want 2", cross_cnt); end
    endtask

    task automatic test_enable_freeze();
        int lat;
        do_reset();
        dir = 1'b1; mag = 10'd250; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (cross_cnt !== 16'd1) begin n_bad++; $display("FAIL en_pre_cross: got %0d want 1", cross_cnt); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (pos !== 7'd50 || cross_cnt !== 16'd1 || land_cnt !== 16'd0 || busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL en_frozen[%0d]: got pos=%0d cross=%0d land=%0d busy=%b ready=%b done=%b want 50/1/0/1/0/0",
                         i, pos, cross_cnt, land_cnt, busy, in_ready, done);
            end
        end
        en = 1'b1;
        lat = 6;
        while (done !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat != 8)            begin n_bad++; $display("FAIL en_lat: got %0d want 8", lat); end
        n_cmp++; if (pos !== 7'd0)        begin n_bad++; $display("FAIL en_pos: got %0d want 0", pos); end
        n_cmp++; if (cross_cnt !== 16'd3) begin n_bad++; $display("FAIL en_cross: got %0d want 3", cross_cnt); end
        n_cmp++; if (land_cnt !== 16'd1)  begin n_bad++; $display("FAIL en_land: got %0d want 1", land_cnt); end
    endtask

    task automatic test_cnt_width();
        int lat;
        logic [1:0] exp_land;
        logic       exp_ovf;
`ifdef DIAL_CNT_SAT_EN
        exp_land = 2'd3; exp_ovf = 1'b1;
`else
        exp_land = 2'd1; exp_ovf = 1'b0;
`endif
        do_reset();
        run_cmd(1'b1, 1'b0, 10'd50, lat);
        for (int i = 0; i < 4; i++) run_cmd(1'b1, 1'b1, 10'd0, lat);
        n_cmp++; if (s_pos !== 7'd0)     begin n_bad++; $display("FAIL small_pos: got %0d want 0", s_pos); end
        n_cmp++; if (s_land !== exp_land) begin n_bad++; $display("FAIL small_land: got %0d want %0d", s_land, exp_land); end
        n_cmp++; if (s_cross !== 2'd1)   begin n_bad++; $display("FAIL small_cross: got %0d want 1", s_cross); end
        n_cmp++; if (s_ovf !== exp_ovf)  begin n_bad++; $display("FAIL small_ovf: got %b want %b", s_ovf, exp_ovf); end
        run_cmd(1'b1, 1'b0, 10'd7, lat);
        n_cmp++; if (s_ovf !== exp_ovf)  begin n_bad++; $display("FAIL small_ovf_sticky: got %b want %b", s_ovf, exp_ovf); end
        n_cmp++; if (s_busy !== 1'b0)    begin n_bad++; $display("FAIL small_busy: got %b want 0", s_busy); end
        do_reset();
        n_cmp++; if (s_ovf !== 1'b0)     begin n_bad++; $display("FAIL small_ovf_rst: got %b want 0", s_ovf); end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1;
        in_valid = 1'b0; dir = 1'b0; mag = '0;
        s_valid = 1'b0; s_dir = 1'b0; s_mag = '0;
        test_reset();
        test_sequence();
        test_long();
        test_from_zero();
        test_enable_freeze();
        test_cnt_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
